// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer control path.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_ALARM = 2'b11
  } state_t;

  // Button indices double as priority: the lowest index wins.
  localparam int NUM_BTN   = 4;
  localparam int BTN_START = 0;
  localparam int BTN_CLR   = 1;
  localparam int BTN_SEC   = 2;
  localparam int BTN_MIN   = 3;

  localparam logic [NUM_BTN-1:0] RPT_BTNS = 4'b1100;

  // Keeps only the highest-priority request (lowest set bit).
  function automatic logic [NUM_BTN-1:0] prio_pick(input logic [NUM_BTN-1:0] req);
    return req & (~req + {{(NUM_BTN-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/btn_edge_rpt.sv
// Press detector for one debounced active-low button with optional hold auto-repeat.
module btn_edge_rpt #(
  parameter int HOLD_DLY  = 12587500,
  parameter int HOLD_PER  = 3146875,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  input  logic accept,
  input  logic cancel,
  output logic press,
  output logic rpt
);

  localparam int HMAX = (HOLD_DLY > HOLD_PER) ? HOLD_DLY : HOLD_PER;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [HW-1:0] DLY_V = HW'(HOLD_DLY);
  localparam logic [HW-1:0] PER_V = HW'(HOLD_PER);
  localparam logic [HW-1:0] ONE_V = HW'(1);

  logic          hist;
  logic          active;
  logic          rep;
  logic [HW-1:0] cnt;

  assign press = hist & ~btn_n;
  // cnt holds cycles since the press (or since the last repeat pulse).
  assign rpt   = REPEAT_EN && active && !btn_n && (rep ? (cnt == PER_V) : (cnt == DLY_V));

  // History register and hold/repeat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= 1'b1;
      active <= 1'b0;
      rep    <= 1'b0;
      cnt    <= {HW{1'b0}};
    end else begin
      hist <= btn_n;
      if (!REPEAT_EN) begin
        active <= 1'b0;
        rep    <= 1'b0;
        cnt    <= {HW{1'b0}};
      end else if (accept) begin
        active <= 1'b1;
        rep    <= 1'b0;
        cnt    <= ONE_V;
      end else if (cancel || btn_n || !active) begin
        active <= 1'b0;
        rep    <= 1'b0;
        cnt    <= {HW{1'b0}};
      end else if (rpt) begin
        rep <= 1'b1;
        cnt <= ONE_V;
      end else begin
        cnt <= cnt + ONE_V;
      end
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Control FSM of the countdown timer: button handling, 1 s prescaler and alarm blink.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV   = 25175000,
  parameter int HOLD_DLY   = 12587500,
  parameter int HOLD_PER   = 3146875,
  parameter int BLINK_DIV  = 6293750,
  parameter int ALARM_SECS = 10
) (
  input  logic       MCLK,
  input  logic       RST_N,
  input  logic       BT_START_N,
  input  logic       BT_CLR_N,
  input  logic       BT_SEC_N,
  input  logic       BT_MIN_N,
  input  logic       CNT_ZERO,
  output logic       CNT_CLR,
  output logic       CNT_INC_SEC,
  output logic       CNT_INC_MIN,
  output logic       CNT_DEC,
  output logic       RUNNING,
  output logic       ALARM,
  output logic [1:0] STATE
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int AW = $clog2(ALARM_SECS + 1);
  localparam logic [PW-1:0] TICK_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_ONE     = PW'(1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [BW-1:0] B_ONE     = BW'(1);
  localparam logic [AW-1:0] ASEC_MAX  = AW'(ALARM_SECS - 1);
  localparam logic [AW-1:0] A_ONE     = AW'(1);

  state_t               state;
  logic [PW-1:0]        presc;
  logic [BW-1:0]        blink;
  logic [AW-1:0]        asecs;
  logic                 clr, inc_sec, inc_min, dec, running, alarm;

  logic [NUM_BTN-1:0]   btn_n, press, rpt, req, win, accept, cancel;
  logic                 any_press, setup;

  assign btn_n     = {BT_MIN_N, BT_SEC_N, BT_CLR_N, BT_START_N};
  assign any_press = |press;
  assign setup     = (state == ST_IDLE) || (state == ST_PAUSE);
  // A repeat pulse behaves like a fresh press but never beats a real one.
  assign req       = press | (rpt & {NUM_BTN{~any_press}});
  assign win       = prio_pick(req);
  assign accept    = win & press & {NUM_BTN{setup}};
  assign cancel    = {NUM_BTN{~setup}} | ({NUM_BTN{any_press}} & ~win);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_edge_rpt #(
      .HOLD_DLY  (HOLD_DLY),
      .HOLD_PER  (HOLD_PER),
      .REPEAT_EN (RPT_BTNS[i])
    ) u_btn (
      .clk    (MCLK),
      .rst_n  (RST_N),
      .btn_n  (btn_n[i]),
      .accept (accept[i]),
      .cancel (cancel[i]),
      .press  (press[i]),
      .rpt    (rpt[i])
    );
  end

  // State machine with registered strobes and status levels.
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      presc   <= {PW{1'b0}};
      blink   <= {BW{1'b0}};
      asecs   <= {AW{1'b0}};
      clr     <= 1'b0;
      inc_sec <= 1'b0;
      inc_min <= 1'b0;
      dec     <= 1'b0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      clr     <= 1'b0;
      inc_sec <= 1'b0;
      inc_min <= 1'b0;
      dec     <= 1'b0;
      case (state)
        ST_IDLE, ST_PAUSE: begin
          if (win[BTN_START]) begin
            if (state == ST_PAUSE || !CNT_ZERO) begin
              state   <= ST_RUN;
              running <= 1'b1;
              if (state == ST_IDLE) presc <= {PW{1'b0}};
            end
          end else if (win[BTN_CLR]) begin
            clr   <= 1'b1;
            state <= ST_IDLE;
          end else if (win[BTN_SEC]) begin
            inc_sec <= 1'b1;
          end else if (win[BTN_MIN]) begin
            inc_min <= 1'b1;
          end
        end
        ST_RUN: begin
          if (CNT_ZERO) begin
            state   <= ST_ALARM;
            running <= 1'b0;
            alarm   <= 1'b1;
            presc   <= {PW{1'b0}};
            blink   <= {BW{1'b0}};
            asecs   <= {AW{1'b0}};
          end else begin
            if (presc == TICK_MAX) begin
              presc <= {PW{1'b0}};
              dec   <= 1'b1;
            end else begin
              presc <= presc + P_ONE;
            end
            if (win[BTN_START]) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end
          end
        end
        ST_ALARM: begin
          if (any_press) begin
            state <= ST_IDLE;
            alarm <= 1'b0;
          end else begin
            if (blink == BLINK_MAX) begin
              blink <= {BW{1'b0}};
              alarm <= ~alarm;
            end else begin
              blink <= blink + B_ONE;
            end
            // Exit after the last tick overrides a coincident blink toggle.
            if (presc == TICK_MAX) begin
              presc <= {PW{1'b0}};
              if (asecs == ASEC_MAX) begin
                asecs <= {AW{1'b0}};
                state <= ST_IDLE;
                alarm <= 1'b0;
              end else begin
                asecs <= asecs + A_ONE;
              end
            end else begin
              presc <= presc + P_ONE;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
          alarm   <= 1'b0;
        end
      endcase
    end
  end

  assign CNT_CLR     = clr;
  assign CNT_INC_SEC = inc_sec;
  assign CNT_INC_MIN = inc_min;
  assign CNT_DEC     = dec;
  assign RUNNING     = running;
  assign ALARM       = alarm;
  assign STATE       = state;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with shortened divider/hold parameters.
module tb_timer_ctrl;

  logic MCLK = 1'b0;
  logic RST_N, BT_START_N, BT_CLR_N, BT_SEC_N, BT_MIN_N, CNT_ZERO;
  logic CNT_CLR, CNT_INC_SEC, CNT_INC_MIN, CNT_DEC, RUNNING, ALARM;
  logic [1:0] STATE;

  localparam logic [3:0] M_CLR = 4'b1000;
  localparam logic [3:0] M_SEC = 4'b0100;
  localparam logic [3:0] M_MIN = 4'b0010;
  localparam logic [3:0] M_DEC = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  bit   mon_en = 1'b0;
  int   c0;

  timer_ctrl #(
    .TICK_DIV   (10),
    .HOLD_DLY   (20),
    .HOLD_PER   (5),
    .BLINK_DIV  (3),
    .ALARM_SECS (2)
  ) dut (
    .MCLK        (MCLK),
    .RST_N       (RST_N),
    .BT_START_N  (BT_START_N),
    .BT_CLR_N    (BT_CLR_N),
    .BT_SEC_N    (BT_SEC_N),
    .BT_MIN_N    (BT_MIN_N),
    .CNT_ZERO    (CNT_ZERO),
    .CNT_CLR     (CNT_CLR),
    .CNT_INC_SEC (CNT_INC_SEC),
    .CNT_INC_MIN (CNT_INC_MIN),
    .CNT_DEC     (CNT_DEC),
    .RUNNING     (RUNNING),
    .ALARM       (ALARM),
    .STATE       (STATE)
  );

  always #5 MCLK = ~MCLK;

  always @(posedge MCLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_at(input int c, input logic [3:0] m);
    int i = 0;
    while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
    exp_q.insert(i, '{cyc: c, mask: m});
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  // Strobe monitor: every cycle the strobe vector must match the scoreboard head or be all zero.
  always @(negedge MCLK) begin
    if (mon_en) begin
      logic [3:0] exp_m;
      exp_m = 4'b0000;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_m = exp_q[0].mask;
        void'(exp_q.pop_front());
      end
      check_val($sformatf("strobe@%0d", cyc),
                {28'd0, CNT_CLR, CNT_INC_SEC, CNT_INC_MIN, CNT_DEC}, {28'd0, exp_m});
    end
  end

  initial begin
    RST_N = 1'b0; BT_START_N = 1'b1; BT_CLR_N = 1'b1; BT_SEC_N = 1'b1; BT_MIN_N = 1'b1;
    CNT_ZERO = 1'b0;

    // Reset state, then release with no clear strobe.
    step(3);
    check_val("rst_state", {30'd0, STATE}, 32'd0);
    check_val("rst_running", {31'd0, RUNNING}, 32'd0);
    check_val("rst_alarm", {31'd0, ALARM}, 32'd0);
    check_val("rst_strobes", {28'd0, CNT_CLR, CNT_INC_SEC, CNT_INC_MIN, CNT_DEC}, 32'd0);
    RST_N = 1'b1;
    mon_en = 1'b1;
    step(5);

    // SEC held 32 cycles: pulses at n+1, n+21, n+26, n+31.
    c0 = cyc;
    expect_at(c0 + 1, M_SEC); expect_at(c0 + 21, M_SEC);
    expect_at(c0 + 26, M_SEC); expect_at(c0 + 31, M_SEC);
    BT_SEC_N = 1'b0;
    step(32);
    BT_SEC_N = 1'b1;
    step(20);

    // MIN alone, then MIN with SEC where SEC wins.
    c0 = cyc; expect_at(c0 + 1, M_MIN);
    BT_MIN_N = 1'b0; step(1); BT_MIN_N = 1'b1; step(3);
    c0 = cyc; expect_at(c0 + 1, M_SEC);
    BT_MIN_N = 1'b0; BT_SEC_N = 1'b0; step(1); BT_MIN_N = 1'b1; BT_SEC_N = 1'b1; step(3);

    // Run, pause after 4 counts, resume: DEC after 6 more counts.
    c0 = cyc;
    expect_at(c0 + 11, M_DEC); expect_at(c0 + 21, M_DEC);
    BT_START_N = 1'b0; step(1); BT_START_N = 1'b1;
    check_val("run_state", {30'd0, STATE}, 32'd1);
    check_val("run_running", {31'd0, RUNNING}, 32'd1);
    step(23);
    BT_START_N = 1'b0; step(1); BT_START_N = 1'b1;
    check_val("pause_state", {30'd0, STATE}, 32'd2);
    check_val("pause_running", {31'd0, RUNNING}, 32'd0);
    step(15);
    c0 = cyc;
    expect_at(c0 + 7, M_DEC); expect_at(c0 + 17, M_DEC);
    BT_START_N = 1'b0; step(1); BT_START_N = 1'b1;
    check_val("resume_state", {30'd0, STATE}, 32'd1);
    step(25);

    // Zero while the prescaler is at its last count: ALARM, no DEC.
    CNT_ZERO = 1'b1;
    step(1);
    check_val("alarm_state", {30'd0, STATE}, 32'd3);
    check_val("alarm_running", {31'd0, RUNNING}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      check_val($sformatf("alarm_blink%0d", k), {31'd0, ALARM}, {31'd0, ((k / 3) % 2) == 0});
      step(1);
    end
    check_val("alarm_end_state", {30'd0, STATE}, 32'd0);
    check_val("alarm_end_level", {31'd0, ALARM}, 32'd0);
    CNT_ZERO = 1'b0;
    step(2);

    // Second run into ALARM, CLR cancels it without a clear strobe.
    BT_START_N = 1'b0; step(1); BT_START_N = 1'b1;
    check_val("run2_state", {30'd0, STATE}, 32'd1);
    step(2);
    CNT_ZERO = 1'b1;
    step(1);
    check_val("alarm2_state", {30'd0, STATE}, 32'd3);
    step(2);
    BT_CLR_N = 1'b0; step(1); BT_CLR_N = 1'b1;
    check_val("alarm_clr_state", {30'd0, STATE}, 32'd0);
    check_val("alarm_clr_level", {31'd0, ALARM}, 32'd0);
    step(2);

    // START ignored while the counters read zero.
    BT_START_N = 1'b0; step(1); BT_START_N = 1'b1;
    check_val("zero_start_state", {30'd0, STATE}, 32'd0);
    step(2);

    // PAUSE then CLR: one clear pulse and back to IDLE.
    CNT_ZERO = 1'b0;
    BT_START_N = 1'b0; step(1); BT_START_N = 1'b1;
    step(2);
    BT_START_N = 1'b0; step(1); BT_START_N = 1'b1;
    check_val("pause2_state", {30'd0, STATE}, 32'd2);
    step(3);
    c0 = cyc; expect_at(c0 + 1, M_CLR);
    BT_CLR_N = 1'b0; step(1); BT_CLR_N = 1'b1;
    check_val("pause_clr_state", {30'd0, STATE}, 32'd0);
    step(3);

    // START and SEC together: START wins, SEC discarded.
    BT_START_N = 1'b0; BT_SEC_N = 1'b0; step(1); BT_START_N = 1'b1; BT_SEC_N = 1'b1;
    check_val("both_state", {30'd0, STATE}, 32'd1);
    step(3);

    // Asynchronous reset mid-run, checked before the next clock edge.
    RST_N = 1'b0;
    #1;
    check_val("async_rst_running", {31'd0, RUNNING}, 32'd0);
    check_val("async_rst_state", {30'd0, STATE}, 32'd0);
    step(2);
    RST_N = 1'b1;
    step(4);

    check_val("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Control FSM for the MM:SS countdown timer. Sequences the four BCD digit counters: setup increments, clear, run/pause and the 1 Hz decrement.
- Replaces the ad-hoc toggle and gating glue between the debouncers and the counters.
- Inputs: debounced active-low buttons and a zero flag from the counters.
- Outputs: registered one-cycle strobes to the counter chain, plus status and alarm levels for LEDs.

Parameters:
- TICK_DIV, 25175000: MCLK cycles per 1 s tick (board clock 25.175 MHz).
- HOLD_DLY, 12587500: cycles a SEC/MIN button must stay held before auto-repeat starts.
- HOLD_PER, 3146875: cycles between auto-repeat pulses.
- BLINK_DIV, 6293750: cycles per ALARM output toggle.
- ALARM_SECS, 10: ticks spent in ALARM before returning to IDLE.

Ports:
- MCLK, input, 1: system clock; all state on the rising edge.
- RST_N, input, 1: asynchronous active-low reset.
- BT_START_N, input, 1: debounced start/stop button, 0 while pressed.
- BT_CLR_N, input, 1: debounced clear button, 0 while pressed.
- BT_SEC_N, input, 1: debounced add-second button, 0 while pressed.
- BT_MIN_N, input, 1: debounced add-minute button, 0 while pressed.
- CNT_ZERO, input, 1: high when all four digits read 0.
- CNT_CLR, output, 1: one-cycle clear strobe.
- CNT_INC_SEC, output, 1: one-cycle +1 s strobe.
- CNT_INC_MIN, output, 1: one-cycle +1 min strobe.
- CNT_DEC, output, 1: one-cycle −1 s strobe.
- RUNNING, output, 1: high in RUN.
- ALARM, output, 1: blinking level in ALARM, 0 otherwise.
- STATE, output, 2: current FSM state.

Behaviour:
- Clocking and reset: one clock, MCLK. RST_N is asynchronous and active-low.
- Reset values:
  - All strobes 0, RUNNING 0, ALARM 0, STATE=IDLE.
  - Prescaler, hold and blink counters 0.
  - Button history registers 1 (released).
  - Reset does not pulse CNT_CLR. Counters keep their contents.
  - Reset asserted mid-operation forces these values immediately.
- Press detection:
  - A press is history=1 and input=0 in cycle n.
  - The resulting strobe is high in cycle n+1 for exactly one cycle. All outputs are registered.
- Simultaneous presses: priority START > CLR > SEC > MIN. Only the winning press acts; the losers are discarded, not queued. At most one strobe per cycle.
- States: IDLE=00, RUN=01, PAUSE=10, ALARM=11.
- IDLE:
  - START with CNT_ZERO=0 → RUN, prescaler cleared to 0.
  - START with CNT_ZERO=1 → ignored.
  - CLR → CNT_CLR pulse.
  - SEC/MIN → INC strobe, with auto-repeat.
- RUN:
  - CNT_ZERO=1 in any cycle → ALARM next cycle, with no DEC that cycle. This has highest priority in RUN.
  - Otherwise the prescaler counts 0..TICK_DIV-1. On reaching TICK_DIV-1 it wraps to 0 and CNT_DEC pulses next cycle.
  - START → PAUSE.
  - CLR, SEC and MIN are ignored.
- PAUSE:
  - Prescaler holds its value.
  - START → RUN, resuming from the held prescaler value.
  - CLR → CNT_CLR pulse and → IDLE.
  - SEC/MIN → INC strobes, with auto-repeat.
- ALARM:
  - Entry clears the prescaler, sets ALARM=1, clears the blink counter.
  - ALARM toggles every BLINK_DIV cycles.
  - After ALARM_SECS prescaler wraps → IDLE, ALARM=0.
  - Any button press → IDLE immediately and is consumed (no strobe).
- Auto-repeat (SEC/MIN, only in IDLE/PAUSE):
  - After an accepted press, the hold counter runs while that button stays low.
  - First repeat pulse after HOLD_DLY cycles from the press cycle, then every HOLD_PER cycles.
  - Release, a higher-priority press, or leaving IDLE/PAUSE stops the repeat and clears the hold counter.
  - Only one button repeats at a time.
- RUNNING = (STATE==RUN), registered with the state.

Decomposition:
- Package timer_pkg:
  - State encodings IDLE/RUN/PAUSE/ALARM.
  - Button priority order constants.
- One sub-module, btn_edge_rpt:
  - History register, press detect, hold/repeat counter.
  - Parameters HOLD_DLY and HOLD_PER, plus REPEAT_EN.
  - Instantiated four times; REPEAT_EN=0 for START and CLR.

Test Plan:
All scenarios use TICK_DIV=10, HOLD_DLY=20, HOLD_PER=5, BLINK_DIV=3, ALARM_SECS=2.
1. Reset: RST_N low with buttons high → all strobes, RUNNING and ALARM 0; STATE=00; no CNT_CLR on release of reset.
2. IDLE, BT_SEC_N low in cycle n, held 32 cycles → CNT_INC_SEC pulses at n+1, n+21, n+26, n+31; no pulses after release.
3. CNT_ZERO=0, START press → STATE=01 next cycle; CNT_DEC every 10 cycles. START after 4 prescaler counts → PAUSE, no DEC. START again → first DEC exactly 6 prescaler counts after resume.
4. In RUN, raise CNT_ZERO → STATE=11 next cycle, no DEC; ALARM toggles every 3 cycles; STATE=00 after 20 cycles. Second run: press CLR during ALARM → IDLE next cycle, no CNT_CLR.
5. IDLE with CNT_ZERO=1, START press → stays IDLE, no strobes. PAUSE, CLR press → one CNT_CLR pulse, STATE=00.
6. IDLE, START and SEC pressed in the same cycle → RUN, no CNT_INC_SEC. RST_N low mid-RUN → RUNNING=0 and STATE=00 without waiting for MCLK.
